bcd_countdown_timer: RTL

- 12-hour-format BCD countdown timer: h1 h0 : m1 m0 : s1 s0, counting down from 11:59:59 max.
- Counterpart of the team's up-counting BCD clock. Same six-digit output format, so the same display path consumes it.
- Host loads a start time, starts, pauses or clears the timer. The block flags expiry with a one-cycle done pulse.

---
 rtl/timer_pkg.sv | 41 ++++
 rtl/bcd_down_digit.sv | 34 +++
 rtl/bcd_countdown_timer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared types and digit limits for the BCD countdown timer.
//   timer_state_t : IDLE / RUN / PAUSED / EXPIRED
//   bcd_digit_t   : one 4-bit BCD digit
//   *_MAX         : highest legal value of each digit position
//   load_legal()  : true when six BCD digits form a legal 12-hour time
// -----------------------------------------------------------------------------
package timer_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSED  = 2'd2,
      EXPIRED = 2'd3
   } timer_state_t;

   localparam bcd_digit_t SEC_ONES_MAX   = 4'd9;
   localparam bcd_digit_t SEC_TENS_MAX   = 4'd5;
   localparam bcd_digit_t MIN_ONES_MAX   = 4'd9;
   localparam bcd_digit_t MIN_TENS_MAX   = 4'd5;
   localparam bcd_digit_t HR_TENS_MAX    = 4'd1;
   localparam bcd_digit_t HR_ONES_MAX_HI = 4'd1;
   // Hour ones limit while the hour tens digit is 0; also its borrow wrap value.
   localparam bcd_digit_t HR_ONES_MAX    = 4'd9;

   function automatic logic load_legal(input bcd_digit_t h1, input bcd_digit_t h0,
                                       input bcd_digit_t m1, input bcd_digit_t m0,
                                       input bcd_digit_t s1, input bcd_digit_t s0);
      logic hr_ok;
      if (h1 == 4'd0)
         hr_ok = (h0 <= HR_ONES_MAX);
      else
         hr_ok = (h1 == HR_TENS_MAX) && (h0 <= HR_ONES_MAX_HI);
      return hr_ok && (m1 <= MIN_TENS_MAX) && (m0 <= MIN_ONES_MAX) &&
             (s1 <= SEC_TENS_MAX) && (s0 <= SEC_ONES_MAX);
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// -----------------------------------------------------------------------------
// bcd_down_digit
// One stage of a BCD borrow chain. When borrow_i is set the digit decrements,
// wrapping 0 -> limit_i and raising borrow_o towards the next digit.
//   value_i  : current digit
//   limit_i  : value loaded when the digit wraps below zero
//   borrow_i : decrement request from the less significant digit
//   next_o   : digit after this stage
//   borrow_o : decrement request to the more significant digit
// -----------------------------------------------------------------------------
module bcd_down_digit
   import timer_pkg::*;
(
   input  logic [3:0] value_i,
   input  logic [3:0] limit_i,
   input  logic       borrow_i,
   output logic [3:0] next_o,
   output logic       borrow_o
);

   always_comb begin
      next_o   = value_i;
      borrow_o = 1'b0;
      if (borrow_i) begin
         if (value_i == 4'd0) begin
            next_o   = limit_i;
            borrow_o = 1'b1;
         end else begin
            next_o = value_i - 4'd1;
         end
      end
   end

endmodule

// File: rtl/bcd_countdown_timer.sv
// -----------------------------------------------------------------------------
// bcd_countdown_timer
// 12-hour BCD countdown timer h1 h0 : m1 m0 : s1 s0 (max 11:59:59).
// Optional build macro TIMER_AUTO_RELOAD_EN: keep a shadow of the last legal
// load and reload it on expiry instead of stopping (unless it is zero).
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   load, ld_*          : one-cycle load strobe with BCD start digits
//   start, pause, clear : control strobes (priority clear > load > pause > start)
//   s0..h1              : registered remaining time
//   running             : registered, high while in RUN
//   done                : one-cycle expiry pulse
//   load_err            : one-cycle pulse on an illegal load
//   dbg_state_o         : current FSM state (timer_state_t encoding)
// -----------------------------------------------------------------------------
module bcd_countdown_timer
   import timer_pkg::*;
#(
   parameter int TICK_DIV = 1,
   parameter int PRE_W    = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] ld_s0,
   input  logic [3:0] ld_s1,
   input  logic [3:0] ld_m0,
   input  logic [3:0] ld_m1,
   input  logic [3:0] ld_h0,
   input  logic [3:0] ld_h1,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   output logic [3:0] s0,
   output logic [3:0] s1,
   output logic [3:0] m0,
   output logic [3:0] m1,
   output logic [3:0] h0,
   output logic [3:0] h1,
   output logic       running,
   output logic       done,
   output logic       load_err,
   output logic [1:0] dbg_state_o
);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   timer_state_t     state_q;
   logic [PRE_W-1:0] pre_q;
   bcd_digit_t       s0_q, s1_q, m0_q, m1_q, h0_q, h1_q;
   logic             running_q, done_q, load_err_q;
`ifdef TIMER_AUTO_RELOAD_EN
   logic [23:0]      shadow_q;
`endif

   bcd_digit_t s0_dec, s1_dec, m0_dec, m1_dec, h0_dec, h1_dec;
   logic       b_s0, b_s1, b_m0, b_m1, b_h0, b_h1;
   logic [23:0] ld_vec, dec_vec;
   logic        load_ok, cnt_zero, dec_zero;

   // Borrow chain always decrements by one second; the FSM decides whether
   // the result is used.
   bcd_down_digit u_s0 (.value_i(s0_q), .limit_i(SEC_ONES_MAX), .borrow_i(1'b1),
                        .next_o(s0_dec), .borrow_o(b_s0));
   bcd_down_digit u_s1 (.value_i(s1_q), .limit_i(SEC_TENS_MAX), .borrow_i(b_s0),
                        .next_o(s1_dec), .borrow_o(b_s1));
   bcd_down_digit u_m0 (.value_i(m0_q), .limit_i(MIN_ONES_MAX), .borrow_i(b_s1),
                        .next_o(m0_dec), .borrow_o(b_m0));
   bcd_down_digit u_m1 (.value_i(m1_q), .limit_i(MIN_TENS_MAX), .borrow_i(b_m0),
                        .next_o(m1_dec), .borrow_o(b_m1));
   bcd_down_digit u_h0 (.value_i(h0_q), .limit_i(HR_ONES_MAX),  .borrow_i(b_m1),
                        .next_o(h0_dec), .borrow_o(b_h0));
   bcd_down_digit u_h1 (.value_i(h1_q), .limit_i(HR_TENS_MAX),  .borrow_i(b_h0),
                        .next_o(h1_dec), .borrow_o(b_h1));

   assign ld_vec  = {ld_h1, ld_h0, ld_m1, ld_m0, ld_s1, ld_s0};
   assign dec_vec = {h1_dec, h0_dec, m1_dec, m0_dec, s1_dec, s0_dec};
   assign load_ok = load_legal(ld_h1, ld_h0, ld_m1, ld_m0, ld_s1, ld_s0);
   // A borrow out of the top digit means every digit was zero.
   assign cnt_zero = b_h1;
   assign dec_zero = (dec_vec == 24'h0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pre_q      <= '0;
         {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q} <= 24'h0;
         running_q  <= 1'b0;
         done_q     <= 1'b0;
         load_err_q <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
         shadow_q   <= 24'h0;
`endif
      end else begin
         done_q     <= 1'b0;
         load_err_q <= 1'b0;
         if (clear) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q} <= 24'h0;
            running_q <= 1'b0;
         end else if (load && (state_q != RUN)) begin
            // Load is not honoured in RUN; there it falls through to pause/start.
            if (load_ok) begin
               {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q} <= ld_vec;
`ifdef TIMER_AUTO_RELOAD_EN
               shadow_q <= ld_vec;
`endif
               if (state_q == EXPIRED)
                  state_q <= IDLE;
            end else begin
               load_err_q <= 1'b1;
            end
         end else begin
            case (state_q)
               IDLE: begin
                  if (start && !pause && !cnt_zero) begin
                     state_q   <= RUN;
                     pre_q     <= '0;
                     running_q <= 1'b1;
                  end
               end
               RUN: begin
                  if (pause) begin
                     // Pause beats a coincident tick: prescaler and digits hold.
                     state_q   <= PAUSED;
                     running_q <= 1'b0;
                  end else if (pre_q == PRE_LAST) begin
                     pre_q <= '0;
                     if (!cnt_zero) begin
                        if (dec_zero) begin
                           done_q <= 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
                           if (shadow_q != 24'h0) begin
                              {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q} <= shadow_q;
                           end else begin
                              {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q} <= 24'h0;
                              state_q   <= EXPIRED;
                              running_q <= 1'b0;
                           end
`else
                           {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q} <= 24'h0;
                           state_q   <= EXPIRED;
                           running_q <= 1'b0;
`endif
                        end else begin
                           {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q} <= dec_vec;
                        end
                     end
                  end else begin
                     pre_q <= pre_q + PRE_W'(1);
                  end
               end
               PAUSED: begin
                  if (start && !pause) begin
                     state_q   <= RUN;
                     running_q <= 1'b1;
                  end
               end
               default: begin
                  // EXPIRED: hold zero, ignore start.
               end
            endcase
         end
      end
   end

   assign s0          = s0_q;
   assign s1          = s1_q;
   assign m0          = m0_q;
   assign m1          = m1_q;
   assign h0          = h0_q;
   assign h1          = h1_q;
   assign running     = running_q;
   assign done        = done_q;
   assign load_err    = load_err_q;
   assign dbg_state_o = state_q;

endmodule
